// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared widths, literal-status and scan FSM encodings
package dpll_pkg;

    localparam int DPLL_WIDTH = 9;

    typedef enum logic [1:0] {
        LIT_TRUE       = 2'd0,
        LIT_FALSE      = 2'd1,
        LIT_UNASSIGNED = 2'd2,
        LIT_EMPTY      = 2'd3
    } lit_status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EVAL  = 3'd2,
        S_VALID = 3'd3,
        S_DONE  = 3'd4
    } scan_state_e;

endpackage

// File: rtl/clause_scanner_if.sv
// rtl/clause_scanner_if.sv - evaluated-clause output stream with valid/ready handshake
interface clause_scanner_if
    import dpll_pkg::*;
#(
    parameter int WIDTH = DPLL_WIDTH
);
    logic [3*WIDTH-1:0] CNF_clause_packed;
    logic               clause_active;
    logic [2:0]         clause_in;
    logic               clause_valid;
    logic               clause_ready;

    modport master (
        output CNF_clause_packed,
        output clause_active,
        output clause_in,
        output clause_valid,
        input  clause_ready
    );

    modport slave (
        input  CNF_clause_packed,
        input  clause_active,
        input  clause_in,
        input  clause_valid,
        output clause_ready
    );
endinterface

// File: rtl/dpll_lit_eval.sv
// rtl/dpll_lit_eval.sv - classify one signed literal against its assignment entry
module dpll_lit_eval
    import dpll_pkg::*;
#(
    parameter int WIDTH = DPLL_WIDTH
) (
    input  logic [WIDTH-1:0] lit,
    input  logic             var_assigned,
    input  logic             var_value,
    output logic [WIDTH-2:0] var_idx,
    output lit_status_e      status
);

    logic [WIDTH-1:0] lit_mag;

    // Variable index is the magnitude; kept separate from the status logic
    // because the caller looks up the assignment table with it.
    assign lit_mag = lit[WIDTH-1] ? (~lit + 1'b1) : lit;
    assign var_idx = lit_mag[WIDTH-2:0];

    // A positive literal is true when its variable is 1, a negative one when it is 0.
    always_comb begin
        if (lit == '0) begin
            status = LIT_EMPTY;
        end else if (!var_assigned) begin
            status = LIT_UNASSIGNED;
        end else if (var_value == !lit[WIDTH-1]) begin
            status = LIT_TRUE;
        end else begin
            status = LIT_FALSE;
        end
    end

endmodule

// File: rtl/clause_scanner.sv
// rtl/clause_scanner.sv - scan stored 3-literal clauses against the variable assignment
module clause_scanner
    import dpll_pkg::*;
#(
    parameter int WIDTH       = DPLL_WIDTH,
    parameter int NUM_CLAUSES = 16,
    parameter int NUM_VARS    = 2**(WIDTH-1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clause_wr_en,
    input  logic [$clog2(NUM_CLAUSES)-1:0] clause_wr_addr,
    input  logic [3*WIDTH-1:0]           clause_wr_data,
    input  logic                         asg_wr_en,
    input  logic [WIDTH-2:0]             asg_var,
    input  logic                         asg_set,
    input  logic                         asg_val,
    input  logic                         asg_clear_all,
    input  logic                         start,
    input  logic [$clog2(NUM_CLAUSES):0] num_clauses,
    clause_scanner_if.master             cs,
    output logic                         busy,
    output logic                         scan_done,
    output logic                         conflict,
    output logic [$clog2(NUM_CLAUSES):0] sat_count
);

    localparam int AW = $clog2(NUM_CLAUSES);
    localparam int CW = AW + 1;

    logic [3*WIDTH-1:0] clause_mem [NUM_CLAUSES];

    logic [NUM_VARS-1:0] asg_assigned_q, asg_assigned_d;
    logic [NUM_VARS-1:0] asg_value_q,    asg_value_d;

    scan_state_e        state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      num_q, num_d;
    logic [3*WIDTH-1:0] rd_data_q, rd_data_d;
    logic [3*WIDTH-1:0] packed_q, packed_d;
    logic               active_q, active_d;
    logic [2:0]         in_q, in_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               conflict_q, conflict_d;
    logic [CW-1:0]      sat_q, sat_d;

    logic [WIDTH-2:0]   var_idx [3];
    lit_status_e        lit_status [3];
    logic               eval_active;
    logic [2:0]         eval_in;
    logic               eval_nonzero;

    // Clause storage: writes only while idle, so a running scan sees a frozen set.
    always_ff @(posedge clk) begin
        if (clause_wr_en && state_q == S_IDLE) begin
            clause_mem[clause_wr_addr] <= clause_wr_data;
        end
    end

    // Assignment table update; a bulk clear wins over a single-entry write.
    always_comb begin
        asg_assigned_d = asg_assigned_q;
        asg_value_d    = asg_value_q;
        if (asg_clear_all) begin
            asg_assigned_d = '0;
        end else if (asg_wr_en) begin
            asg_assigned_d[asg_var] = asg_set;
            if (asg_set) begin
                asg_value_d[asg_var] = asg_val;
            end
        end
    end

    // Assignment table registers; reset unassigns every variable.
    always_ff @(posedge clk) begin
        if (rst) begin
            asg_assigned_q <= '0;
            asg_value_q    <= '0;
        end else begin
            asg_assigned_q <= asg_assigned_d;
            asg_value_q    <= asg_value_d;
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_lit
        dpll_lit_eval #(.WIDTH(WIDTH)) u_lit_eval (
            .lit          (rd_data_q[k*WIDTH +: WIDTH]),
            .var_assigned (asg_assigned_q[var_idx[k]]),
            .var_value    (asg_value_q[var_idx[k]]),
            .var_idx      (var_idx[k]),
            .status       (lit_status[k])
        );
    end

    // Reduce the three literal statuses to clause-level results.
    always_comb begin
        eval_active  = 1'b1;
        eval_in      = 3'b000;
        eval_nonzero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (lit_status[k] == LIT_TRUE)       eval_active  = 1'b0;
            if (lit_status[k] == LIT_UNASSIGNED) eval_in[k]   = 1'b1;
            if (lit_status[k] != LIT_EMPTY)      eval_nonzero = 1'b1;
        end
    end

    // Scan sequencing: READ fetches, EVAL registers results, VALID waits for ready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        rd_data_d  = rd_data_q;
        packed_d   = packed_q;
        active_d   = active_q;
        in_d       = in_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        conflict_d = conflict_q;
        sat_d      = sat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_clauses;
                    conflict_d = 1'b0;
                    sat_d      = '0;
                    idx_d      = '0;
                    if (num_clauses == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                rd_data_d = clause_mem[idx_q];
                state_d   = S_EVAL;
            end
            S_EVAL: begin
                packed_d = rd_data_q;
                active_d = eval_active;
                in_d     = eval_in;
                valid_d  = 1'b1;
                if (!eval_active) begin
                    sat_d = sat_q + 1'b1;
                end
                if (eval_active && eval_in == 3'b000 && eval_nonzero) begin
                    conflict_d = 1'b1;
                end
                state_d = S_VALID;
            end
            S_VALID: begin
                if (cs.clause_ready) begin
                    valid_d = 1'b0;
                    if ({1'b0, idx_q} == num_q - 1'b1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Scan state and registered outputs; reset aborts any scan silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            rd_data_q  <= '0;
            packed_q   <= '0;
            active_q   <= 1'b0;
            in_q       <= 3'b000;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
            sat_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            rd_data_q  <= rd_data_d;
            packed_q   <= packed_d;
            active_q   <= active_d;
            in_q       <= in_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
            sat_q      <= sat_d;
        end
    end

    assign cs.CNF_clause_packed = packed_q;
    assign cs.clause_active     = active_q;
    assign cs.clause_in         = in_q;
    assign cs.clause_valid      = valid_q;
    assign busy                 = busy_q;
    assign scan_done            = done_q;
    assign conflict             = conflict_q;
    assign sat_count            = sat_q;

endmodule

// File: tb/tb_clause_scanner.sv
// tb/tb_clause_scanner.sv - scoreboard bench for clause_scanner with a literal-level reference model
module tb_clause_scanner;

    localparam int W  = 9;
    localparam int NC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clause_wr_en = 1'b0;
    logic [3:0]  clause_wr_addr = '0;
    logic [26:0] clause_wr_data = '0;
    logic        asg_wr_en = 1'b0;
    logic [7:0]  asg_var = '0;
    logic        asg_set = 1'b0;
    logic        asg_val = 1'b0;
    logic        asg_clear_all = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  num_clauses = '0;
    logic        busy, scan_done, conflict;
    logic [4:0]  sat_count;

    clause_scanner_if #(.WIDTH(W)) cs_if ();

    clause_scanner #(.WIDTH(W), .NUM_CLAUSES(NC)) dut (
        .clk            (clk),
        .rst            (rst),
        .clause_wr_en   (clause_wr_en),
        .clause_wr_addr (clause_wr_addr),
        .clause_wr_data (clause_wr_data),
        .asg_wr_en      (asg_wr_en),
        .asg_var        (asg_var),
        .asg_set        (asg_set),
        .asg_val        (asg_val),
        .asg_clear_all  (asg_clear_all),
        .start          (start),
        .num_clauses    (num_clauses),
        .cs             (cs_if.master),
        .busy           (busy),
        .scan_done      (scan_done),
        .conflict       (conflict),
        .sat_count      (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] pk;
        logic        act;
        logic [2:0]  inv;
    } exp_t;

    typedef struct {
        int sat;
        bit conf;
    } sum_t;

    exp_t        exp_q [$];
    sum_t        sum_q [$];
    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;

    logic [26:0] m_mem [NC];
    bit          m_asg [256];
    bit          m_val [256];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [26:0] mk(input int l2, input int l1, input int l0);
        logic [8:0] a, b, c;
        a = 9'(l2);
        b = 9'(l1);
        c = 9'(l0);
        return {a, b, c};
    endfunction

    // Reference: evaluate each literal directly from the clause rules.
    task automatic model_clause(input logic [26:0] w, output logic act, output logic [2:0] inv, output bit confl);
        bit any_nz;
        logic signed [8:0] s;
        int l, v;
        act = 1'b1;
        inv = 3'b000;
        any_nz = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s = w[k*9 +: 9];
            l = int'(s);
            if (l != 0) begin
                any_nz = 1'b1;
                v = (l < 0) ? -l : l;
                if (m_asg[v]) begin
                    if (m_val[v] == (l > 0)) act = 1'b0;
                end else begin
                    inv[k] = 1'b1;
                end
            end
        end
        confl = act && (inv == 3'b000) && any_nz;
    endtask

    // Ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       cs_if.clause_ready = 1'b1;
            1:       cs_if.clause_ready = 1'($urandom_range(0, 1));
            default: cs_if.clause_ready = 1'b0;
        endcase
    end

    // Monitor: pops expectations on handshakes and scan_done, checks hold stability
    logic        prev_hold = 1'b0;
    logic [26:0] prev_pk;
    logic        prev_act;
    logic [2:0]  prev_in;
    always @(negedge clk) begin
        exp_t e;
        sum_t s;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk(cs_if.clause_valid && cs_if.CNF_clause_packed == prev_pk &&
                    cs_if.clause_active == prev_act && cs_if.clause_in == prev_in,
                    "hold_stable", {4'(cs_if.clause_valid), cs_if.CNF_clause_packed[26:0], 1'b0} , {4'd1, prev_pk, 1'b0});
            end
            if (cs_if.clause_valid && cs_if.clause_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_clause", 32'(cs_if.CNF_clause_packed), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cs_if.CNF_clause_packed == e.pk, "clause_packed", 32'(cs_if.CNF_clause_packed), 32'(e.pk));
                    chk(cs_if.clause_active == e.act, "clause_active", 32'(cs_if.clause_active), 32'(e.act));
                    chk(cs_if.clause_in == e.inv, "clause_in", 32'(cs_if.clause_in), 32'(e.inv));
                end
            end
            if (scan_done) begin
                done_cnt++;
                if (sum_q.size() == 0) begin
                    chk(1'b0, "unexpected_scan_done", 32'd1, 32'd0);
                end else begin
                    s = sum_q.pop_front();
                    chk(32'(sat_count) == 32'(s.sat), "sat_count", 32'(sat_count), 32'(s.sat));
                    chk(conflict == s.conf, "conflict", 32'(conflict), 32'(s.conf));
                end
            end
            prev_hold = cs_if.clause_valid && !cs_if.clause_ready;
            prev_pk   = cs_if.CNF_clause_packed;
            prev_act  = cs_if.clause_active;
            prev_in   = cs_if.clause_in;
        end
    end

    task automatic write_clause(input int addr, input logic [26:0] data);
        clause_wr_en   = 1'b1;
        clause_wr_addr = 4'(addr);
        clause_wr_data = data;
        m_mem[addr]    = data;
        @(posedge clk); #1;
        clause_wr_en   = 1'b0;
    endtask

    task automatic set_asg(input int v, input bit set, input bit val);
        asg_wr_en = 1'b1;
        asg_var   = 8'(v);
        asg_set   = set;
        asg_val   = val;
        m_asg[v]  = set;
        if (set) m_val[v] = val;
        @(posedge clk); #1;
        asg_wr_en = 1'b0;
    endtask

    task automatic clear_all(input bit with_write, input int v);
        asg_clear_all = 1'b1;
        asg_wr_en     = with_write;
        asg_var       = 8'(v);
        asg_set       = 1'b1;
        asg_val       = 1'b1;
        for (int i = 0; i < 256; i++) m_asg[i] = 1'b0;
        @(posedge clk); #1;
        asg_clear_all = 1'b0;
        asg_wr_en     = 1'b0;
    endtask

    task automatic run_scan(input int n);
        int   sat = 0;
        bit   conf = 1'b0;
        int   start_cnt = done_cnt;
        bit   seen = 1'b0;
        exp_t e;
        bit   c;
        sum_t s;
        for (int i = 0; i < n; i++) begin
            e.pk = m_mem[i];
            model_clause(m_mem[i], e.act, e.inv, c);
            exp_q.push_back(e);
            if (!e.act) sat++;
            if (c) conf = 1'b1;
        end
        s.sat = sat;
        s.conf = conf;
        sum_q.push_back(s);
        @(posedge clk); #1;
        start = 1'b1;
        num_clauses = 5'(n);
        @(posedge clk); #1;
        start = 1'b0;
        clause_wr_en   = 1'b1;
        clause_wr_addr = 4'($urandom_range(0, NC - 1));
        clause_wr_data = 27'($urandom);
        @(negedge clk);
        chk(busy == 1'b1, "busy_after_start", 32'(busy), 32'd1);
        @(posedge clk); #1;
        clause_wr_en = 1'b0;
        @(negedge clk);
        chk(cs_if.clause_valid == 1'b0, "valid_before_latency", 32'(cs_if.clause_valid), 32'd0);
        @(negedge clk);
        chk(cs_if.clause_valid == 1'b1, "valid_at_latency3", 32'(cs_if.clause_valid), 32'd1);
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (done_cnt != start_cnt) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        chk(seen, "scan_done_timeout", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk(done_cnt == start_cnt + 1, "scan_done_once", 32'(done_cnt - start_cnt), 32'd1);
        chk(exp_q.size() == 0, "clauses_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=%0d required=0", 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        for (int i = 0; i < 256; i++) begin
            m_asg[i] = 1'b0;
            m_val[i] = 1'b0;
        end
        for (int i = 0; i < NC; i++) m_mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(cs_if.CNF_clause_packed == '0, "rst_packed", 32'(cs_if.CNF_clause_packed), 32'd0);
        chk({cs_if.clause_active, cs_if.clause_in, cs_if.clause_valid} == 5'd0, "rst_clause_flags",
            32'({cs_if.clause_active, cs_if.clause_in, cs_if.clause_valid}), 32'd0);
        chk({busy, scan_done, conflict} == 3'd0, "rst_status", 32'({busy, scan_done, conflict}), 32'd0);
        chk(sat_count == '0, "rst_sat_count", 32'(sat_count), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) write_clause(i, '0);

        // Two-clause example: one unresolved, one satisfied
        write_clause(0, mk(-1, 6, 7));
        write_clause(1, mk(1, 2, 25));
        set_asg(1, 1, 1);
        set_asg(6, 1, 0);
        run_scan(2);
        chk(sat_count == 5'd1, "ex1_sat_count", 32'(sat_count), 32'd1);
        chk(conflict == 1'b0, "ex1_conflict", 32'(conflict), 32'd0);

        // All literals false -> conflict, held after scan_done
        write_clause(0, mk(-5, -6, 8));
        set_asg(5, 1, 1);
        set_asg(6, 1, 1);
        set_asg(8, 1, 0);
        run_scan(1);
        repeat (3) @(posedge clk);
        #1;
        chk(conflict == 1'b1, "conflict_sticky", 32'(conflict), 32'd1);
        chk(sat_count == 5'd0, "sat_hold", 32'(sat_count), 32'd0);

        // Backpressure: ready low for several cycles on clause 0
        write_clause(0, mk(-1, 6, 7));
        write_clause(1, mk(3, 0, -9));
        ready_mode = 2;
        fork
            run_scan(2);
            begin
                repeat (10) @(negedge clk);
                ready_mode = 0;
            end
        join

        // Empty scan
        @(posedge clk); #1;
        sum_q.push_back('{sat: 0, conf: 1'b0});
        start = 1'b1;
        num_clauses = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk(scan_done == 1'b1 && busy == 1'b1, "empty_done_busy", 32'({scan_done, busy}), 32'd3);
        chk(cs_if.clause_valid == 1'b0, "empty_no_valid", 32'(cs_if.clause_valid), 32'd0);
        @(negedge clk);
        chk(scan_done == 1'b0 && busy == 1'b0, "empty_after", 32'({scan_done, busy}), 32'd0);
        @(posedge clk); #1;

        // Reset during VALID
        write_clause(0, mk(0, 0, 3));
        set_asg(3, 1, 1);
        ready_mode = 2;
        @(posedge clk); #1;
        start = 1'b1;
        num_clauses = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(cs_if.clause_valid == 1'b1, "abort_in_valid", 32'(cs_if.clause_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) m_asg[i] = 1'b0;
        chk({cs_if.CNF_clause_packed, cs_if.clause_active, cs_if.clause_in, cs_if.clause_valid} == '0,
            "abort_outputs", 32'(cs_if.CNF_clause_packed), 32'd0);
        chk({busy, scan_done, conflict, sat_count} == '0, "abort_status", 32'({busy, scan_done, conflict, sat_count}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(scan_done == 1'b0, "abort_no_done", 32'(scan_done), 32'd0);
        end
        @(posedge clk); #1;
        ready_mode = 0;
        run_scan(1);

        // All unassigned, then rescan after clear_all
        write_clause(0, mk(-1, 46, 71));
        set_asg(46, 1, 0);
        clear_all(1'b1, 71);
        run_scan(1);
        clear_all(1'b0, 0);
        run_scan(1);

        // Randomized scans
        ready_mode = 1;
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(1, NC);
            for (int i = 0; i < n; i++) begin
                int l [3];
                for (int k = 0; k < 3; k++) begin
                    r = $urandom_range(0, 9);
                    l[k] = (r < 2) ? 0 : ($urandom_range(1, 20) * (($urandom_range(0, 1) == 1) ? 1 : -1));
                end
                write_clause(i, mk(l[2], l[1], l[0]));
            end
            if (it % 7 == 3) clear_all(1'b1, $urandom_range(1, 20));
            for (int v = 1; v <= 20; v++) begin
                r = $urandom_range(0, 5);
                if (r == 0) set_asg(v, 1'b0, 1'b0);
                else if (r < 4) set_asg(v, 1'b1, 1'($urandom_range(0, 1)));
            end
            run_scan(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
